// File: rtl/sonic_sensor_array.sv
// Sequential scanner for single-pin ultrasonic rangers: pulses each enabled channel,
// times the echo high period and keeps a per-channel result/status table for readback.
module sonic_sensor_array #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned T_PULSE     = 500,
  parameter int unsigned T_HOLDOFF   = 75000,
  parameter int unsigned T_ECHO_WAIT = 2000,
  parameter int unsigned T_ECHO_MAX  = 1850000,
  parameter int unsigned T_GAP       = 20000,
  localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              auto_en,
  input  logic [NUM_CH-1:0] ch_en,
  inout  wire  [NUM_CH-1:0] sig,
  output logic              busy,
  output logic              done,
  input  logic [SEL_W-1:0]  sel,
  output logic [CNT_W-1:0]  out_data,
  output logic [2:0]        out_status
);

  // Last counter value of each timed phase; a zero-length phase still takes one cycle.
  localparam logic [CNT_W-1:0] PULSE_LAST = (T_PULSE > 0) ? CNT_W'(T_PULSE - 1) : '0;
  localparam logic [CNT_W-1:0] HOLD_LAST  = (T_HOLDOFF > 0) ? CNT_W'(T_HOLDOFF - 1) : '0;
  localparam logic [CNT_W-1:0] WAIT_LAST  = (T_ECHO_WAIT > 0) ? CNT_W'(T_ECHO_WAIT - 1) : '0;
  localparam logic [CNT_W-1:0] GAP_LAST   = (T_GAP > 0) ? CNT_W'(T_GAP - 1) : '0;
  localparam logic [CNT_W-1:0] ECHO_MAX   = CNT_W'(T_ECHO_MAX);

  typedef enum logic [2:0] {
    StIdle, StPulse, StHoldoff, StWaitRise, StMeasure, StStore, StGap, StNext
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic               done_q, done_d;
  logic [NUM_CH-1:0]  sync1_q, sync2_q;
  logic [CNT_W-1:0]   result_q [NUM_CH];
  logic [2:0]         status_q [NUM_CH];

  logic               wr_en;
  logic [CNT_W-1:0]   wr_data;
  logic [2:0]         wr_status;
  logic [SEL_W-1:0]   first_idx, next_idx;
  logic               next_found;
  logic               echo;

  assign echo    = sync2_q[ch_q];
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_drive
    assign sig[g] = (state_q == StPulse && ch_q == SEL_W'(g)) ? 1'b1 : 1'bz;
  end

  // Descending search so the lowest qualifying index wins.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (ch_en[i]) first_idx = SEL_W'(i);
      if (mask_q[i] && (i > int'(ch_q))) begin
        next_found = 1'b1;
        next_idx   = SEL_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    mask_d    = mask_q;
    done_d    = 1'b0;
    wr_en     = 1'b0;
    wr_data   = cnt_q;
    wr_status = 3'b100;
    unique case (state_q)
      StIdle: begin
        if (req || auto_en) begin
          mask_d = ch_en;
          if (|ch_en) begin
            state_d = StPulse;
            ch_d    = first_idx;
            cnt_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StPulse: begin
        if (cnt_q >= PULSE_LAST) begin
          state_d = StHoldoff;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHoldoff: begin
        if (cnt_q >= HOLD_LAST) begin
          state_d = StWaitRise;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitRise: begin
        // The high cycle that ends the wait is the first counted echo cycle.
        if (echo) begin
          state_d = StMeasure;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q >= WAIT_LAST) begin
          wr_en     = 1'b1;
          wr_data   = '1;
          wr_status = 3'b101;
          state_d   = StGap;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StMeasure: begin
        if (!echo || cnt_q >= ECHO_MAX) begin
          state_d = StStore;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StStore: begin
        wr_en     = 1'b1;
        wr_data   = cnt_q;
        wr_status = {1'b1, (cnt_q >= ECHO_MAX), 1'b0};
        state_d   = StGap;
        cnt_d     = '0;
      end
      StGap: begin
        if (cnt_q >= GAP_LAST) begin
          state_d = StNext;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StNext: begin
        if (next_found) begin
          ch_d    = next_idx;
          state_d = StPulse;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ch_q    <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        result_q[i] <= '0;
        status_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      sync1_q <= sig;
      sync2_q <= sync1_q;
      if (wr_en) begin
        result_q[ch_q] <= wr_data;
        status_q[ch_q] <= wr_status;
      end
    end
  end

  always_comb begin
    out_data   = '0;
    out_status = '0;
    if (int'(sel) < int'(NUM_CH)) begin
      out_data   = result_q[sel];
      out_status = status_q[sel];
    end
  end

endmodule

// File: doc/sonic_sensor_array.md
SONIC_SENSOR_ARRAY -- requirements
Module: sonic_sensor_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of single-pin ultrasonic channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the echo counter and result.
REQ-003 SHALL have parameter T_PULSE, default 500, meaning the trigger high time in clk cycles.
REQ-004 SHALL have parameter T_HOLDOFF, default 75000, meaning the cycles between trigger release and echo sampling.
REQ-005 SHALL have parameter T_ECHO_WAIT, default 2000, meaning the maximum cycles to wait for the echo rising edge.
REQ-006 SHALL have parameter T_ECHO_MAX, default 1850000, meaning the echo saturation count.
REQ-007 SHALL have parameter T_GAP, default 20000, meaning the inter-channel quiet time in cycles.
REQ-008 SHALL have port clk, input, 1, the clock.
REQ-009 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-010 SHALL have ports req (in, 1, single-scan request pulse), auto_en (in, 1, continuous scanning) and ch_en (in, NUM_CH, channel enable mask).
REQ-011 SHALL have port sig, inout, NUM_CH, one bidirectional sensor pin per channel.
REQ-012 SHALL have outputs busy (1, scan in progress) and done (1, one-cycle end-of-scan pulse).
REQ-013 SHALL have ports sel (in, clog2(NUM_CH)), out_data (out, CNT_W) and out_status (out, 3: {valid, overrange, timeout}), giving combinational readback of channel sel.

Function
REQ-014 SHALL pass each sig input through a 2-flop synchronizer before any use.
REQ-015 SHALL implement the states IDLE, PULSE, HOLDOFF, WAIT_RISE, MEASURE, STORE, GAP and NEXT.
REQ-016 SHALL start a scan from IDLE when req=1 or auto_en=1, latching ch_en into an internal mask at that edge.
REQ-017 SHALL ignore req while busy=1, and changes to ch_en SHALL NOT affect a scan in progress.
REQ-018 SHALL visit enabled channels in ascending index order, skipping masked channels with no cycles spent on them.
REQ-019 SHALL, in PULSE, drive sig[ch]=1 for exactly T_PULSE cycles and leave every other sig bit at Z at all times.
REQ-020 SHALL, in HOLDOFF, hold all sig at Z for exactly T_HOLDOFF cycles, then enter WAIT_RISE.
REQ-021 SHALL, in WAIT_RISE, go to MEASURE on the synchronized sig[ch]=1, or after T_ECHO_WAIT cycles without it record the channel as timed out: result={CNT_W{1'b1}}, status=3'b101.
REQ-022 SHALL, in MEASURE, count cycles while the synchronized sig[ch]=1, ending on its falling edge or when the count reaches T_ECHO_MAX.
REQ-023 SHALL, in STORE, write the count to result[ch] with status 3'b100, or 3'b110 if the count is saturated at T_ECHO_MAX.
REQ-024 SHALL spend T_GAP cycles in GAP after each visited channel, then select the next enabled channel or finish the scan.
REQ-025 SHALL, at scan end, assert done for exactly one cycle and return to IDLE; with auto_en=1 a new scan SHALL start on the following cycle.
REQ-026 SHALL, when req=1 with a zero mask, pulse done on the next cycle, keep busy=0 and drive no sig.
REQ-027 SHALL assert busy=1 in every state except IDLE.
REQ-028 SHALL leave result and status of channels not visited in a scan unchanged.
REQ-029 SHALL keep all counters saturating, with no wrap-around for any parameter values that fit CNT_W.

Reset
REQ-030 SHALL, on rst, set the state to IDLE, busy=0, done=0, all sig=Z, all results=0, all status=0 and the latched mask=0.
REQ-031 SHALL, on rst mid-scan, release sig to Z on the same edge and discard any partial measurement.

Verification (NUM_CH=2, T_PULSE=4, T_HOLDOFF=6, T_ECHO_WAIT=10, T_ECHO_MAX=50, T_GAP=3)
REQ-032 SHALL verify: ch_en=2'b01, req pulse, model echo 20 cycles high -> sig[0] high exactly 4 cycles, sig[1] always Z, result[0]=20, status 3'b100, one done pulse.
REQ-033 SHALL verify: ch_en=2'b11, no echo on ch1 -> result[1]=FFFFFFFF, status[1]=3'b101, ch0 measured normally, done after ch1's GAP.
REQ-034 SHALL verify: echo held high 80 cycles -> result=50, status 3'b110, scan continues.
REQ-035 SHALL verify: auto_en=1, ch_en=2'b10 -> back-to-back scans of ch1 only, done one cycle apart from the next PULSE entry, results updated each scan.
REQ-036 SHALL verify: rst asserted during MEASURE -> sig Z, busy=0, all result/status 0 on the next cycle; a later req works normally.
REQ-037 SHALL verify: req during busy and req with ch_en=0 -> the first is ignored, the second gives done after 1 cycle with busy=0.
